// File: rtl/dac_sine_seq_if.sv
// Serial DAC pin bundle: frame select, serial clock and data.
// master drives the pins (sequencer), slave observes them (DAC/model).
interface dac_sine_seq_if;
  logic dac_sync;
  logic dac_sclk;
  logic dac_din;

  modport master (
    output dac_sync,
    output dac_sclk,
    output dac_din
  );

  modport slave (
    input dac_sync,
    input dac_sclk,
    input dac_din
  );
endinterface

// File: rtl/dac_sine_seq.sv
// Multi-channel sine sequencer for a quad 16-bit serial DAC (24-bit frames).
// Ports: clk/rst_n, enable, sim_update, phase_step, phase_off -> dac pins, busy, round_done, overrun.
module dac_sine_seq #(
  parameter int NCH      = 4,
  parameter int SCLK_DIV = 3,
  parameter int GAP_CYC  = 2,
  parameter int UPD_DIV  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sim_update,
  input  logic [5:0]       phase_step,
  input  logic [6*NCH-1:0] phase_off,
  dac_sine_seq_if.master   dac,
  output logic             busy,
  output logic             round_done,
  output logic             overrun
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_e;

  localparam int CMAX =
    (2*SCLK_DIV > GAP_CYC) ? 2*SCLK_DIV : GAP_CYC;
  localparam int CW = $clog2(CMAX+1);
  localparam logic [CW-1:0] S_LAST = CW'(SCLK_DIV-1);
  localparam logic [CW-1:0] B_LAST = CW'(2*SCLK_DIV-1);
  localparam logic [CW-1:0] B_HIGH = CW'(SCLK_DIV);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC-1);
  localparam logic [1:0]    CH_LAST = 2'(NCH-1);
  localparam logic [15:0]   T_LAST = 16'(UPD_DIV-1);

  localparam logic [15:0] LUT [64] = '{
    16'h8000, 16'h8C8B, 16'h98F8, 16'hA527,
    16'hB0FB, 16'hBC56, 16'hC71C, 16'hD133,
    16'hDA82, 16'hE2F1, 16'hEA6D, 16'hF0E2,
    16'hF641, 16'hFA7C, 16'hFD89, 16'hFF61,
    16'hFFFF, 16'hFF61, 16'hFD89, 16'hFA7C,
    16'hF641, 16'hF0E2, 16'hEA6D, 16'hE2F1,
    16'hDA82, 16'hD133, 16'hC71C, 16'hBC56,
    16'hB0FB, 16'hA527, 16'h98F8, 16'h8C8B,
    16'h8000, 16'h7374, 16'h6707, 16'h5AD8,
    16'h4F04, 16'h43A9, 16'h38E3, 16'h2ECC,
    16'h257D, 16'h1D0E, 16'h1592, 16'h0F1D,
    16'h09BE, 16'h0583, 16'h0276, 16'h009E,
    16'h0000, 16'h009E, 16'h0276, 16'h0583,
    16'h09BE, 16'h0F1D, 16'h1592, 16'h1D0E,
    16'h257D, 16'h2ECC, 16'h38E3, 16'h43A9,
    16'h4F04, 16'h5AD8, 16'h6707, 16'h7374
  };

  state_e              st_q, st_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4:0]          bit_q, bit_d;
  logic [1:0]          ch_q, ch_d;
  logic [5:0]          acc_q, acc_d;
  logic [5:0]          step_q, step_d;
  logic [NCH-1:0][5:0] off_q, off_d;
  logic                sim_q, sim_d;
  logic [15:0]         tmr_q, tmr_d;
  logic                pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                sync_q, sclk_q, din_q;
  logic                busy_q, rd_q;

  logic        tick, rnd_end, launch, active;
  logic [5:0]  ph;
  logic [1:0]  ld;
  logic [23:0] frame;

  always_comb begin
    tick    = (tmr_q == T_LAST);
    tmr_d   = tick ? '0 : tmr_q + 16'd1;
    rnd_end = (st_q == GAP) && (cnt_q == G_LAST)
              && (ch_q == CH_LAST);
    // a tick landing on the final gap cycle restarts
    // back-to-back and is not an overrun
    launch  = enable &&
              (((st_q == IDLE) && tick) ||
               (rnd_end && (tick || pend_q)));

    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (rnd_end) begin
      pend_d = 1'b0;
    end else if (tick && (st_q != IDLE)) begin
      pend_d = 1'b1;
      ovr_d  = 1'b1;
    end

    acc_d  = rnd_end ? acc_q + step_q : acc_q;
    step_d = launch ? phase_step : step_q;
    off_d  = launch ? phase_off : off_q;
    sim_d  = launch ? sim_update : sim_q;

    st_d  = st_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    ch_d  = ch_q;
    unique case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (launch) begin
          st_d  = SETUP;
          ch_d  = 2'd0;
          bit_d = 5'd23;
        end
      end
      SETUP: begin
        if (cnt_q == S_LAST) begin
          st_d  = SHIFT;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == B_LAST) begin
          cnt_d = '0;
          if (bit_q == 5'd0) st_d = HOLD;
          else bit_d = bit_q - 5'd1;
        end
      end
      HOLD: begin
        if (cnt_q == S_LAST) begin
          st_d  = GAP;
          cnt_d = '0;
        end
      end
      GAP: begin
        if (cnt_q == G_LAST) begin
          cnt_d = '0;
          bit_d = 5'd23;
          if (ch_q != CH_LAST) begin
            st_d = SETUP;
            ch_d = ch_q + 2'd1;
          end else if (launch) begin
            st_d = SETUP;
            ch_d = 2'd0;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase

    // pins are registered from next-state values so
    // they line up with the state register
    active = (st_d == SETUP) || (st_d == SHIFT)
             || (st_d == HOLD);
    ph     = acc_d + off_d[ch_d];
    ld     = sim_d ? ((ch_d == CH_LAST) ? 2'b10 : 2'b00)
                   : 2'b01;
    frame  = {2'b00, ld, 1'b0, ch_d, 1'b0, LUT[ph]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      ch_q   <= '0;
      acc_q  <= '0;
      step_q <= '0;
      off_q  <= '0;
      sim_q  <= 1'b0;
      tmr_q  <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      sync_q <= 1'b1;
      sclk_q <= 1'b0;
      din_q  <= 1'b0;
      busy_q <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      ch_q   <= ch_d;
      acc_q  <= acc_d;
      step_q <= step_d;
      off_q  <= off_d;
      sim_q  <= sim_d;
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      sync_q <= !active;
      sclk_q <= (st_d == SHIFT) && (cnt_d < B_HIGH);
      din_q  <= active && frame[bit_d];
      busy_q <= (st_d != IDLE);
      rd_q   <= (st_d == GAP) && (cnt_d == G_LAST)
                && (ch_d == CH_LAST);
    end
  end

  assign dac.dac_sync = sync_q;
  assign dac.dac_sclk = sclk_q;
  assign dac.dac_din  = din_q;
  assign busy         = busy_q;
  assign round_done   = rd_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_dac_sine_seq.sv
// Bench for dac_sine_seq: frame scoreboard on DUT A, overrun timing on DUT B.
// Expected frames are pushed per round; a pin monitor decodes and pops them.
module tb_dac_sine_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        en_a, sim_a;
  logic [5:0]  step_a;
  logic [23:0] off_a;
  logic        busy_a, rd_a, ovr_a;
  logic        en_b;
  logic        busy_b, rd_b, ovr_b;

  dac_sine_seq_if dac_a ();
  dac_sine_seq_if dac_b ();

  dac_sine_seq u_a (
    .clk(clk), .rst_n(rst_n),
    .enable(en_a), .sim_update(sim_a),
    .phase_step(step_a), .phase_off(off_a),
    .dac(dac_a),
    .busy(busy_a), .round_done(rd_a),
    .overrun(ovr_a)
  );

  dac_sine_seq #(.UPD_DIV(500)) u_b (
    .clk(clk), .rst_n(rst_n),
    .enable(en_b), .sim_update(1'b0),
    .phase_step(6'd0), .phase_off(24'd0),
    .dac(dac_b),
    .busy(busy_b), .round_done(rd_b),
    .overrun(ovr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q [$];
  logic trunc_ok = 1'b0;
  logic b_done = 1'b0;

  // channel-0 codes for acc = 0,7,14,...,63,6
  localparam logic [15:0] WRAP [11] = '{
    16'h8000, 16'hD133, 16'hFD89, 16'hF0E2,
    16'hB0FB, 16'h5AD8, 16'h1592, 16'h009E,
    16'h257D, 16'h7374, 16'hC71C
  };

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  task automatic wait_rd_a(input string nm);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = rd_a;
    end
    if (!got) fail(nm);
  endtask

  task automatic wait_busy_a(input string nm);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 1100 && !got; i++) begin
      @(negedge clk);
      got = busy_a;
    end
    if (!got) fail(nm);
  endtask

  task automatic push4(input logic [7:0] h0, h1, h2, h3,
                       input logic [15:0] c0, c1, c2, c3);
    exp_q.push_back({h0, c0});
    exp_q.push_back({h1, c1});
    exp_q.push_back({h2, c2});
    exp_q.push_back({h3, c3});
  endtask

  task automatic chk_reset(input string nm);
    check({nm, "_sync"}, dac_a.dac_sync, 1);
    check({nm, "_sclk"}, dac_a.dac_sclk, 0);
    check({nm, "_din"}, dac_a.dac_din, 0);
    check({nm, "_busy"}, busy_a, 0);
    check({nm, "_rd"}, rd_a, 0);
    check({nm, "_ovr"}, ovr_a, 0);
  endtask

  // pin monitor / scoreboard for DUT A
  int nbits = 0, fidx = 0, nfalls = 0, rd_cnt = 0;
  int nround = 0, fall_cyc = 0, rise_cyc = 0;
  logic [23:0] sr;
  initial begin
    logic p_sync, p_sclk, p_busy, p_rd;
    logic [23:0] e;
    p_sync = 1'b1; p_sclk = 1'b0;
    p_busy = 1'b0; p_rd = 1'b0;
    sr = '0;
    forever begin
      @(negedge clk);
      if (busy_a && !p_busy) begin
        nround++;
        check("busy_with_sync", dac_a.dac_sync, 0);
        if (nround >= 2 && nround <= 14)
          check("round_period", cyc - rise_cyc, 1000);
        rise_cyc = cyc;
        fidx = 0;
      end
      if (!dac_a.dac_sync && p_sync) begin
        if (fidx > 0)
          check("frame_len", cyc - fall_cyc, 152);
        fall_cyc = cyc;
        fidx++;
        nfalls++;
        nbits = 0;
        sr = '0;
      end
      if (!dac_a.dac_sync && p_sclk && !dac_a.dac_sclk) begin
        sr = {sr[22:0], dac_a.dac_din};
        nbits++;
      end
      if (dac_a.dac_sync && !p_sync) begin
        if (nbits == 24) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_frame");
          end else begin
            e = exp_q.pop_front();
            check("frame", sr, e);
          end
        end else if (!trunc_ok) begin
          fail("short_frame");
        end
      end
      if (rd_a) begin
        rd_cnt++;
        check("rd_width", p_rd, 0);
      end
      p_sync = dac_a.dac_sync;
      p_sclk = dac_a.dac_sclk;
      p_busy = busy_a;
      p_rd   = rd_a;
    end
  end

  // overrun and back-to-back restart on DUT B
  initial begin
    logic got;
    @(posedge rst_n);
    got = 1'b0;
    for (int i = 0; i < 700 && !got; i++) begin
      @(negedge clk);
      got = busy_b;
    end
    if (!got) fail("b_start");
    check("b_start_sync", dac_b.dac_sync, 0);
    check("b_ovr_pre", ovr_b, 0);
    got = 1'b0;
    for (int i = 0; i < 800 && !got; i++) begin
      @(negedge clk);
      got = rd_b;
    end
    if (!got) fail("b_round_done");
    check("b_ovr_set", ovr_b, 1);
    check("b_rd_sync", dac_b.dac_sync, 1);
    @(negedge clk);
    check("b_restart_sync", dac_b.dac_sync, 0);
    check("b_restart_busy", busy_b, 1);
    b_done = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int falls0;
    rst_n = 1'b0;
    en_a = 1'b0; sim_a = 1'b0;
    step_a = '0; off_a = '0;
    en_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");

    off_a = {6'd48, 6'd32, 6'd16, 6'd0};
    push4(8'h10, 8'h12, 8'h14, 8'h16,
          16'h8000, 16'hFFFF, 16'h8000, 16'h0000);
    en_a = 1'b1;
    en_b = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_rd_a("rd_round1");
    repeat (5) @(negedge clk);
    check("rd_count1", rd_cnt, 1);

    for (int r = 0; r < 11; r++) begin
      step_a = 6'd7;
      off_a  = '0;
      push4(8'h10, 8'h12, 8'h14, 8'h16,
            WRAP[r], WRAP[r], WRAP[r], WRAP[r]);
      wait_rd_a("rd_wrap");
    end

    // acc = 13 here
    step_a = 6'd0;
    sim_a  = 1'b1;
    off_a  = {6'd20, 6'd0, 6'd51, 6'd60};
    push4(8'h00, 8'h02, 8'h04, 8'h26,
          16'hE2F1, 16'h8000, 16'hFA7C, 16'h7374);
    wait_rd_a("rd_sim");

    sim_a = 1'b0;
    off_a = '0;
    push4(8'h10, 8'h12, 8'h14, 8'h16,
          16'hFA7C, 16'hFA7C, 16'hFA7C, 16'hFA7C);
    wait_busy_a("busy_drop_round");
    repeat (160) @(negedge clk);
    en_a = 1'b0;
    wait_rd_a("rd_after_drop");
    falls0 = nfalls;
    repeat (2500) @(negedge clk);
    check("rd_count14", rd_cnt, 14);
    check("no_sync_after_drop", nfalls - falls0, 0);
    check("idle_busy", busy_a, 0);
    check("no_overrun_a", ovr_a, 0);
    check("queue_drained", exp_q.size(), 0);
    check("b_finished", b_done, 1);

    trunc_ok = 1'b1;
    en_a = 1'b1;
    wait_busy_a("busy_before_reset");
    repeat (20) @(negedge clk);
    check("in_shift_sync", dac_a.dac_sync, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    repeat (3) @(negedge clk);
    check("queue_empty_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
